// File: rtl/gray_bin_codec_pipe_if.sv
// Word stream into and out of the Gray/binary codec pipe.
// slave is the codec side, master is the producer/consumer side.
interface gray_bin_codec_pipe_if #(
   parameter int WIDTH = 4
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_data;
   logic             in_mode;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_data;
   logic             out_mode;
   logic             out_step_err;
   logic [15:0]      err_count;

   modport slave (
      input  in_valid, in_data, in_mode, out_ready,
      output in_ready, out_valid, out_data, out_mode,
      output out_step_err, err_count
   );

   modport master (
      output in_valid, in_data, in_mode, out_ready,
      input  in_ready, out_valid, out_data, out_mode,
      input  out_step_err, err_count
   );
endinterface

// File: rtl/gray_bin_codec_pipe.sv
// Registered Gray<->binary converter with skid buffer
// and a single-bit-step checker on the Gray input stream.
module gray_bin_codec_pipe #(
   parameter int WIDTH    = 4,
   parameter bit CHECK_EN = 1'b1
) (
   input logic clk,
   input logic rst,
   gray_bin_codec_pipe_if.slave bus
);
   localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

   logic             main_valid;
   logic [WIDTH-1:0] main_data;
   logic             main_mode;
   logic             main_err;
   logic             skid_valid;
   logic [WIDTH-1:0] skid_data;
   logic             skid_mode;
   logic             skid_err;
   logic             prev_valid;
   logic [WIDTH-1:0] prev_gray;
   logic [15:0]      err_count;

   logic [WIDTH-1:0] conv_data;
   logic [WIDTH-1:0] diff;
   logic             one_hot;
   logic             step_err;
   logic             in_ready;
   logic             acc;
   logic             drain;
   logic             load_main;
   logic             load_skid;
   logic             skid_move;

   function automatic logic [WIDTH-1:0] gray2bin(
      input logic [WIDTH-1:0] g
   );
      logic [WIDTH-1:0] b;
      b[WIDTH-1] = g[WIDTH-1];
      for (int i = WIDTH - 2; i >= 0; i--) begin
         b[i] = b[i+1] ^ g[i];
      end
      return b;
   endfunction

   always_comb begin
      conv_data = '0;
      if (bus.in_mode) begin
         conv_data = bus.in_data ^ (bus.in_data >> 1);
      end else begin
         conv_data = gray2bin(bus.in_data);
      end
   end

   // a legal Gray step has exactly one differing bit
   assign diff     = bus.in_data ^ prev_gray;
   assign one_hot  = (diff != '0) && ((diff & (diff - ONE)) == '0);
   assign step_err = CHECK_EN && !bus.in_mode && prev_valid && !one_hot;

   assign in_ready  = !skid_valid && !rst;
   assign acc       = bus.in_valid && in_ready;
   assign drain     = main_valid && bus.out_ready;
   assign skid_move = skid_valid && (drain || !main_valid);
   assign load_main = acc && (!main_valid || drain) && !skid_valid;
   assign load_skid = acc && !load_main;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         main_valid <= 1'b0;
         main_data  <= '0;
         main_mode  <= 1'b0;
         main_err   <= 1'b0;
      end else if (skid_move) begin
         main_valid <= 1'b1;
         main_data  <= skid_data;
         main_mode  <= skid_mode;
         main_err   <= skid_err;
      end else if (load_main) begin
         main_valid <= 1'b1;
         main_data  <= conv_data;
         main_mode  <= bus.in_mode;
         main_err   <= step_err;
      end else if (drain) begin
         main_valid <= 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         skid_valid <= 1'b0;
         skid_data  <= '0;
         skid_mode  <= 1'b0;
         skid_err   <= 1'b0;
      end else if (load_skid) begin
         skid_valid <= 1'b1;
         skid_data  <= conv_data;
         skid_mode  <= bus.in_mode;
         skid_err   <= step_err;
      end else if (skid_move) begin
         skid_valid <= 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         prev_valid <= 1'b0;
         prev_gray  <= '0;
         err_count  <= '0;
      end else if (acc) begin
         prev_valid <= !bus.in_mode;
         if (!bus.in_mode) begin
            prev_gray <= bus.in_data;
         end
         if (step_err && (err_count != 16'hFFFF)) begin
            err_count <= err_count + 16'd1;
         end
      end
   end

   assign bus.in_ready     = in_ready;
   assign bus.out_valid    = main_valid;
   assign bus.out_data     = main_data;
   assign bus.out_mode     = main_mode;
   assign bus.out_step_err = main_err;
   assign bus.err_count    = err_count;
endmodule

// File: tb/tb_gray_bin_codec_pipe.sv
// Directed table-driven bench for gray_bin_codec_pipe,
// WIDTH=4 and WIDTH=8 instances sharing one clock.
module tb_gray_bin_codec_pipe;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   total = 0;
   int   bad = 0;

   always #5 clk = ~clk;

   gray_bin_codec_pipe_if #(.WIDTH(4)) b4 ();
   gray_bin_codec_pipe_if #(.WIDTH(8)) b8 ();

   gray_bin_codec_pipe #(.WIDTH(4), .CHECK_EN(1'b1)) dut4 (
      .clk (clk),
      .rst (rst),
      .bus (b4)
   );

   gray_bin_codec_pipe #(.WIDTH(8), .CHECK_EN(1'b1)) dut8 (
      .clk (clk),
      .rst (rst),
      .bus (b8)
   );

   typedef struct {
      logic [3:0]  data;
      logic        mode;
      logic [3:0]  exp_data;
      logic        exp_err;
      logic [15:0] exp_cnt;
   } vec_t;

   vec_t vecs[$];

   logic [3:0] gseq[16] = '{
      4'b0000, 4'b0001, 4'b0011, 4'b0010,
      4'b0110, 4'b0111, 4'b0101, 4'b0100,
      4'b1100, 4'b1101, 4'b1111, 4'b1110,
      4'b1010, 4'b1011, 4'b1001, 4'b1000
   };
   logic [3:0] bp_in[6]  = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6};
   logic [3:0] bp_exp[6] = '{4'b0001, 4'b0011, 4'b0010,
                             4'b0110, 4'b0111, 4'b0101};

   function automatic vec_t mk(
      input logic [3:0] d, input logic m, input logic [3:0] ed,
      input logic ee, input logic [15:0] ec
   );
      vec_t v;
      v.data = d; v.mode = m; v.exp_data = ed;
      v.exp_err = ee; v.exp_cnt = ec;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      int idx;
      int got;
      bit saw_stall;
      bit acc_now;
      bit hold;
      logic [3:0] held;

      b4.in_valid = 1'b0; b4.in_data = '0; b4.in_mode = 1'b0;
      b4.out_ready = 1'b1;
      b8.in_valid = 1'b0; b8.in_data = '0; b8.in_mode = 1'b0;
      b8.out_ready = 1'b1;

      for (int k = 0; k < 16; k++)
         vecs.push_back(mk(gseq[k], 1'b0, k[3:0], 1'b0, 16'd0));
      vecs.push_back(mk(4'b0101, 1'b1, 4'b0111, 1'b0, 16'd0));
      vecs.push_back(mk(4'b1111, 1'b1, 4'b1000, 1'b0, 16'd0));
      vecs.push_back(mk(4'b0000, 1'b0, 4'b0000, 1'b0, 16'd0));
      vecs.push_back(mk(4'b0011, 1'b0, 4'b0010, 1'b1, 16'd1));
      vecs.push_back(mk(4'b0011, 1'b0, 4'b0010, 1'b1, 16'd2));
      vecs.push_back(mk(4'b0010, 1'b0, 4'b0011, 1'b0, 16'd2));
      vecs.push_back(mk(4'b0110, 1'b1, 4'b0101, 1'b0, 16'd2));
      vecs.push_back(mk(4'b1111, 1'b0, 4'b1010, 1'b0, 16'd2));

      // reset state
      step(); step();
      chk("rst_in_ready", 32'(b4.in_ready), 32'd0);
      chk("rst_out_valid", 32'(b4.out_valid), 32'd0);
      chk("rst_err_count", 32'(b4.err_count), 32'd0);
      rst = 1'b0;
      #1;
      chk("post_rst_in_ready", 32'(b4.in_ready), 32'd1);

      // table: gray count, bin->gray, step checker
      foreach (vecs[i]) begin
         b4.in_valid = 1'b1;
         b4.in_data  = vecs[i].data;
         b4.in_mode  = vecs[i].mode;
         step();
         chk($sformatf("v%0d_valid", i), 32'(b4.out_valid), 32'd1);
         chk($sformatf("v%0d_data", i), 32'(b4.out_data),
             32'(vecs[i].exp_data));
         chk($sformatf("v%0d_mode", i), 32'(b4.out_mode),
             32'(vecs[i].mode));
         chk($sformatf("v%0d_err", i), 32'(b4.out_step_err),
             32'(vecs[i].exp_err));
         chk($sformatf("v%0d_cnt", i), 32'(b4.err_count),
             32'(vecs[i].exp_cnt));
      end
      b4.in_valid = 1'b0;
      step();
      chk("table_drained", 32'(b4.out_valid), 32'd0);

      // backpressure: stall out_ready for cycles 2..4
      idx = 0; got = 0; saw_stall = 1'b0;
      for (int c = 0; c < 30 && got < 6; c++) begin
         b4.in_valid  = (idx < 6);
         b4.in_data   = (idx < 6) ? bp_in[idx] : 4'd0;
         b4.in_mode   = 1'b1;
         b4.out_ready = !(c >= 2 && c <= 4);
         #0;
         if (!b4.in_ready) saw_stall = 1'b1;
         acc_now = b4.in_valid && b4.in_ready;
         if (b4.out_valid && b4.out_ready) begin
            chk($sformatf("bp_word%0d", got), 32'(b4.out_data),
                32'(bp_exp[got]));
            got++;
         end
         hold = b4.out_valid && !b4.out_ready;
         held = b4.out_data;
         step();
         if (acc_now) idx++;
         if (hold) chk("bp_stable", 32'(b4.out_data), 32'(held));
      end
      b4.in_valid  = 1'b0;
      b4.out_ready = 1'b1;
      chk("bp_count", 32'(got), 32'd6);
      chk("bp_in_ready_dropped", 32'(saw_stall), 32'd1);
      step();
      chk("bp_no_dup", 32'(b4.out_valid), 32'd0);

      // reset with main and skid full
      b4.out_ready = 1'b0;
      b4.in_valid  = 1'b1;
      b4.in_mode   = 1'b0;
      b4.in_data   = 4'b1111;
      step();
      b4.in_data   = 4'b0000;
      step();
      b4.in_valid  = 1'b0;
      chk("full_in_ready", 32'(b4.in_ready), 32'd0);
      chk("full_out_valid", 32'(b4.out_valid), 32'd1);
      chk("full_err_count", 32'(b4.err_count), 32'd3);
      #2 rst = 1'b1;
      #1;
      chk("async_out_valid", 32'(b4.out_valid), 32'd0);
      chk("async_in_ready", 32'(b4.in_ready), 32'd0);
      chk("async_err_count", 32'(b4.err_count), 32'd0);
      step(); step();
      rst = 1'b0;
      b4.out_ready = 1'b1;
      b4.in_valid  = 1'b1;
      b4.in_data   = 4'b0101;
      step();
      b4.in_valid  = 1'b0;
      chk("after_rst_valid", 32'(b4.out_valid), 32'd1);
      chk("after_rst_data", 32'(b4.out_data), 32'b0110);
      chk("after_rst_err", 32'(b4.out_step_err), 32'd0);
      chk("after_rst_cnt", 32'(b4.err_count), 32'd0);

      // WIDTH=8 conversions
      b8.in_valid = 1'b1;
      b8.in_mode  = 1'b0;
      b8.in_data  = 8'hC0;
      step();
      chk("w8_g2b", 32'(b8.out_data), 32'h80);
      chk("w8_g2b_err", 32'(b8.out_step_err), 32'd0);
      b8.in_mode  = 1'b1;
      b8.in_data  = 8'hFF;
      step();
      chk("w8_b2g", 32'(b8.out_data), 32'h80);
      chk("w8_b2g_mode", 32'(b8.out_mode), 32'd1);

      // saturation: repeated 8'h00, first one unchecked
      b8.in_mode = 1'b0;
      b8.in_data = 8'h00;
      for (int n = 0; n < 65535; n++) step();
      chk("sat_fffe", 32'(b8.err_count), 32'hFFFE);
      chk("sat_flag", 32'(b8.out_step_err), 32'd1);
      step();
      chk("sat_ffff", 32'(b8.err_count), 32'hFFFF);
      step(); step(); step();
      chk("sat_hold", 32'(b8.err_count), 32'hFFFF);
      b8.in_valid = 1'b0;
      step();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
